fifo_rd_packer: RTL
===================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer for the fifo1 dual-clock FIFO, running in the rclk domain.
//  Pops DSIZE-bit entries via the rempty/rinc/rdata port.
//  Packs NBYTES entries little-endian into one OSIZE-bit word.
//  Presents each word on a valid/ready output; flush emits a partial word.
// PARAMETERS
//  DSIZE   8  width of one FIFO entry (must match fifo1 DSIZE)
//  NBYTES  4  entries packed per output word, >=2
//  OSIZE   DSIZE*NBYTES  output word width (derived, do not override)
// PORTS
//  rclk       in   1                  read clock; single clock domain
//  rrst_n     in   1                  reset, synchronous, active-low
//  rempty     in   1                  fifo1 empty; rdata valid when 0
//  rdata      in   DSIZE              fifo1 read data, combinational from current rptr
//  rinc       out  1                  pop strobe to fifo1, one entry per rclk with rinc=1
//  flush      in   1                  level; emit the held partial word
//  out_valid  out  1                  out_data/out_bytes valid
//  out_ready  in   1                  downstream accepts the word when high with out_valid
//  out_data   out  OSIZE              packed word; entry k in [k*DSIZE +: DSIZE]
//  out_bytes  out  $clog2(NBYTES+1)   valid entries in out_data, 1..NBYTES
//  words_out  out  16                 count of accepted words; wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset, sampled on rclk while rrst_n=0:
//   - state=FILL, lane count cnt=0.
//   - out_valid=0, out_data=0, out_bytes=0, words_out=0.
//   - rinc is gated by rrst_n, so it is 0 throughout reset.
//  States: FILL (collecting entries) and OUT (holding a word).
//  FILL:
//   - rinc = rrst_n & ~rempty & ~flush, combinational.
//   - On an edge with rinc=1, rdata is written to lane cnt and cnt increments.
//   - If cnt was NBYTES-1, the next state is OUT with out_valid=1, out_bytes=NBYTES, cnt=0.
//   - Latency: word visible one rclk after the edge that pops its last entry.
//   - flush=1 with cnt>0: no pop; next state OUT, out_bytes=cnt, unused lanes=0, cnt=0.
//   - flush=1 with cnt=0: no pop and no output; remain in FILL.
//  OUT:
//   - rinc=0. out_data and out_bytes are held stable while out_ready=0.
//   - When out_valid & out_ready on an edge:
//     - out_valid=0, out_data=0, out_bytes=0;
//     - words_out increments (mod 2^16);
//     - next state is FILL.
//   - flush is ignored in OUT.
//   - Peak throughput is NBYTES entries per NBYTES+1 rclk.
//  Empty FIFO: rinc is never asserted while rempty=1; the partial word is held indefinitely.
//  Reset mid-word: the partial word and any pending out_valid are discarded; the next word starts at lane 0.
//  rdata is sampled only on edges where rinc=1; the block never reads fifo1 memory ahead.
// TESTING (DSIZE=8, NBYTES=4)
//  1. Reset while rempty=0 and out_ready=1:
//     rinc=0 all reset cycles; out_valid=0, out_data=0, words_out=0.
//  2. FIFO holds 11,22,33,44; out_ready=1:
//     rinc=1 for 4 consecutive rclk; next rclk out_valid=1, out_data=0x44332211, out_bytes=4; words_out=1.
//  3. 8 entries 01..08; out_ready=0 for 5 rclk after the first word:
//     out_data held at 0x04030201 and rinc=0 while stalled;
//     then 0x08070605 follows; words_out=2, nothing lost.
//  4. Pop AA,BB, then assert flush:
//     out_data=0x0000BBAA, out_bytes=2, no rinc that cycle.
//     Flush again with cnt=0: out_valid stays 0.
//  5. rempty toggling 1/0 between entries C1..C4:
//     rinc only in rempty=0 cycles; out_data=0xC4C3C2C1.
//  6. rrst_n=0 for 1 rclk after 2 pops of 5A,5B, then supply 01..04:
//     out_data=0x04030201, words_out=1 (counted from reset).

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side consumer for the fifo1 dual-clock FIFO (rclk domain).
// Pops DSIZE-bit entries and packs NBYTES of them little-endian into one output word.
module fifo_rd_packer #(
    parameter int DSIZE  = 8,
    parameter int NBYTES = 4,
    parameter int OSIZE  = DSIZE * NBYTES
) (
    input  logic                        rclk,
    input  logic                        rrst_n,
    input  logic                        rempty,
    input  logic [DSIZE-1:0]            rdata,
    output logic                        rinc,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OSIZE-1:0]            out_data,
    output logic [$clog2(NBYTES+1)-1:0] out_bytes,
    output logic [15:0]                 words_out
);
    localparam int BW = $clog2(NBYTES + 1);
    localparam logic [BW-1:0] LAST = BW'(NBYTES - 1);

    typedef enum logic {FILL = 1'b0, OUT = 1'b1} state_t;

    state_t           state;
    logic [BW-1:0]    cnt;
    logic [OSIZE-1:0] pack_q;
    logic [OSIZE-1:0] next_word;

    // Handshake: a word transfers on any rclk edge where out_valid and out_ready are
    // both high; until then out_data/out_bytes stay frozen and no entry is popped.
    assign rinc = rrst_n & ~rempty & ~flush & (state == FILL);

    // Partial word with the current rdata dropped into lane cnt.
    always_comb begin
        next_word = pack_q;
        for (int k = 0; k < NBYTES; k++) begin
            if (cnt == BW'(k)) begin
                next_word[k*DSIZE +: DSIZE] = rdata;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state     <= FILL;
            cnt       <= '0;
            pack_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            words_out <= '0;
        end else if (state == FILL) begin
            if (rinc) begin
                if (cnt == LAST) begin
                    out_data  <= next_word;
                    out_bytes <= BW'(NBYTES);
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    pack_q    <= '0;
                    state     <= OUT;
                end else begin
                    pack_q <= next_word;
                    cnt    <= cnt + 1'b1;
                end
            end else if (flush && cnt != '0) begin
                // pack_q is cleared after every word, so unused lanes read as zero
                out_data  <= pack_q;
                out_bytes <= cnt;
                out_valid <= 1'b1;
                cnt       <= '0;
                pack_q    <= '0;
                state     <= OUT;
            end
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_bytes <= '0;
                words_out <= words_out + 16'd1;
                state     <= FILL;
            end
        end
    end
endmodule
